// File: rtl/modn_updown_counter.sv
// modn_updown_counter: synchronous mod-N up/down counter with enable, clear,
// clamped parallel load, registered wrap pulse and combinational at_term.
// Optional build macro MODN_COUNTER_SAT_EN selects saturating mode. In that
// mode wrap is never raised, and a registered sat output flags a step held
// at a limit.
module modn_updown_counter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 16,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
`ifdef MODN_COUNTER_SAT_EN
   output logic             sat,
`endif
   output logic             at_term
);

   // Extended-width constants so MODULUS == 2**WIDTH compares without overflow
   localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   TERM_W = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] TERM   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RST_VAL);

   // Elaboration-time parameter legality checks
   if ((MODULUS < 2) || (64'(MODULUS) > (64'(1) << WIDTH))) begin : g_bad_modulus
      $error("modn_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end
   if (RST_VAL >= MODULUS) begin : g_bad_rst_val
      $error("modn_updown_counter: RST_VAL must be below MODULUS");
   end

   logic [WIDTH:0]   count_ext;
   logic [WIDTH-1:0] count_nxt;
   logic             wrap_nxt;
   logic             at_top;
   logic             at_zero;
`ifdef MODN_COUNTER_SAT_EN
   logic             sat_nxt;
`endif

   assign count_ext = {1'b0, count};
   assign at_top    = (count_ext == TERM_W);
   assign at_zero   = (count == '0);

   // Terminal value depends on the direction currently requested
   assign at_term = up_dn ? at_top : at_zero;

   // Next-state selection: clr > load > en; rst is applied in the register
   always_comb begin
      count_nxt = count;
      wrap_nxt  = 1'b0;
`ifdef MODN_COUNTER_SAT_EN
      sat_nxt   = 1'b0;
`endif
      if (clr) begin
         count_nxt = RST_V;
      end else if (load) begin
         count_nxt = ({1'b0, load_val} < MOD_W) ? load_val : TERM;
      end else if (en) begin
         if (up_dn) begin
            if (at_top) begin
`ifdef MODN_COUNTER_SAT_EN
               count_nxt = TERM;
               sat_nxt   = 1'b1;
`else
               count_nxt = '0;
               wrap_nxt  = 1'b1;
`endif
            end else begin
               count_nxt = count + WIDTH'(1);
            end
         end else begin
            if (at_zero) begin
`ifdef MODN_COUNTER_SAT_EN
               count_nxt = '0;
               sat_nxt   = 1'b1;
`else
               count_nxt = TERM;
               wrap_nxt  = 1'b1;
`endif
            end else begin
               count_nxt = count - WIDTH'(1);
            end
         end
      end
   end

   // Output registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= RST_V;
         wrap  <= 1'b0;
`ifdef MODN_COUNTER_SAT_EN
         sat   <= 1'b0;
`endif
      end else begin
         count <= count_nxt;
         wrap  <= wrap_nxt;
`ifdef MODN_COUNTER_SAT_EN
         sat   <= sat_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: a mod-16 and a mod-10 instance share one
// directed stimulus stream; an arithmetic model of each is checked every
// cycle, and hand-computed literals pin the key sequences.
module tb_modn_updown_counter;

   logic       clk = 1'b0;
   logic       rst, en, up_dn, clr, load;
   logic [3:0] load_val;

   logic [3:0] count16, count10;
   logic       wrap16, wrap10, at16, at10;
`ifdef MODN_COUNTER_SAT_EN
   logic       sat16, sat10;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Model state for each instance
   int m16 = 0, m10 = 0;
   bit mw16, mw10, ms16, ms10;
   bit started = 1'b0;

   always #5 clk = ~clk;

   modn_updown_counter u16 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .count(count16), .wrap(wrap16),
`ifdef MODN_COUNTER_SAT_EN
      .sat(sat16),
`endif
      .at_term(at16)
   );

   modn_updown_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u10 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .count(count10), .wrap(wrap10),
`ifdef MODN_COUNTER_SAT_EN
      .sat(sat10),
`endif
      .at_term(at10)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Spec-level behaviour of one edge for modulus m
   task automatic model_step(input int m, inout int c, inout bit w, inout bit s);
      w = 1'b0;
      s = 1'b0;
      if (rst || clr) begin
         c = 0;
      end else if (load) begin
         c = (int'(load_val) < m) ? int'(load_val) : m - 1;
      end else if (en) begin
`ifdef MODN_COUNTER_SAT_EN
         if (up_dn) begin
            if (c == m - 1) s = 1'b1; else c = c + 1;
         end else begin
            if (c == 0) s = 1'b1; else c = c - 1;
         end
`else
         if (up_dn) begin
            w = (c == m - 1);
            c = (c + 1) % m;
         end else begin
            w = (c == 0);
            c = (c + m - 1) % m;
         end
`endif
      end
   endtask

   always @(posedge clk) begin
      model_step(16, m16, mw16, ms16);
      model_step(10, m10, mw10, ms10);
      started = 1'b1;
   end

   // Single compare process, away from the active edge
   always @(negedge clk) begin
      if (started) begin
         chk("count16", 32'(count16), 32'(m16));
         chk("wrap16", 32'(wrap16), 32'(mw16));
         chk("at_term16", 32'(at16), 32'(up_dn ? (m16 == 15) : (m16 == 0)));
         chk("count10", 32'(count10), 32'(m10));
         chk("wrap10", 32'(wrap10), 32'(mw10));
         chk("at_term10", 32'(at10), 32'(up_dn ? (m10 == 9) : (m10 == 0)));
`ifdef MODN_COUNTER_SAT_EN
         chk("sat16", 32'(sat16), 32'(ms16));
         chk("sat10", 32'(sat10), 32'(ms10));
`endif
      end
   end

   // Drive one edge worth of inputs and settle just past the edge
   task automatic step(input bit e, input bit u, input bit c, input bit l, input int lv);
      en       = e;
      up_dn    = u;
      clr      = c;
      load     = l;
      load_val = 4'(lv);
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;

      // Reset for two edges
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("rst_count16", 32'(count16), 32'd0);
      chk("rst_count10", 32'(count10), 32'd0);
      chk("rst_wrap16", 32'(wrap16), 32'd0);
      rst = 1'b0;

      // Up count for 20 edges
      for (int i = 1; i <= 20; i++) begin
         step(1, 1, 0, 0, 0);
`ifndef MODN_COUNTER_SAT_EN
         chk("up_count16", 32'(count16), 32'(i % 16));
         chk("up_wrap16", 32'(wrap16), 32'(i == 16));
         chk("up_count10", 32'(count10), 32'(i % 10));
         chk("up_wrap10", 32'(wrap10), 32'(i % 10 == 0));
`endif
      end
      chk("up_at_term16", 32'(at16), 32'(count16 == 4'd15));

      // Clear, then count down through the mod-10 wrap
      step(0, 0, 1, 0, 0);
      chk("clr_count16", 32'(count16), 32'd0);
      for (int k = 1; k <= 11; k++) begin
         step(1, 0, 0, 0, 0);
`ifndef MODN_COUNTER_SAT_EN
         chk("dn_count10", 32'(count10), 32'((10 - k % 10) % 10));
         chk("dn_wrap10", 32'(wrap10), 32'(k == 1 || k == 11));
         chk("dn_count16", 32'(count16), 32'((16 - k) % 16));
`endif
      end

      // Load beats en; out-of-range load clamps
      step(1, 1, 0, 1, 7);
      chk("load7_16", 32'(count16), 32'd7);
      chk("load7_10", 32'(count10), 32'd7);
      chk("load7_wrap10", 32'(wrap10), 32'd0);
      step(1, 1, 0, 1, 12);
      chk("load12_16", 32'(count16), 32'd12);
      chk("load12_10", 32'(count10), 32'd9);

      // clr beats load; rst mid-count
      step(0, 1, 0, 1, 5);
      step(1, 1, 1, 1, 3);
      chk("clr_load16", 32'(count16), 32'd0);
      chk("clr_load10", 32'(count10), 32'd0);
      step(0, 1, 0, 1, 8);
      rst = 1'b1;
      step(1, 1, 0, 0, 0);
      chk("midrst16", 32'(count16), 32'd0);
      chk("midrst_wrap16", 32'(wrap16), 32'd0);
      rst = 1'b0;
      step(1, 1, 0, 0, 0);
      chk("resume16", 32'(count16), 32'd1);

      // Direction flip at the top: 14 -> 15,14,15,0
      step(0, 1, 0, 1, 14);
      step(1, 1, 0, 0, 0);
      chk("flip_a16", 32'(count16), 32'd15);
      step(1, 0, 0, 0, 0);
      chk("flip_b16", 32'(count16), 32'd14);
      step(1, 1, 0, 0, 0);
      chk("flip_c16", 32'(count16), 32'd15);
      step(1, 1, 0, 0, 0);
`ifndef MODN_COUNTER_SAT_EN
      chk("flip_d16", 32'(count16), 32'd0);
      chk("flip_wrap16", 32'(wrap16), 32'd1);
`endif

      // Hold with en low, direction toggling for at_term
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);

      // Boundary loads: 15, 10, 9
      step(1, 1, 0, 1, 15);
      chk("load15_16", 32'(count16), 32'd15);
      chk("load15_10", 32'(count10), 32'd9);
      step(1, 1, 0, 0, 0);
      step(0, 1, 0, 1, 10);
      chk("load10_10", 32'(count10), 32'd9);
      chk("load10_16", 32'(count16), 32'd10);
      step(0, 1, 0, 1, 9);

      // Saturation sequence: 13 -> 14,15,15,15, then down at 0
      step(0, 1, 0, 1, 13);
      for (int j = 1; j <= 4; j++) begin
         step(1, 1, 0, 0, 0);
`ifdef MODN_COUNTER_SAT_EN
         chk("sat_count16", 32'(count16), 32'(j >= 2 ? 15 : 14));
         chk("sat_flag16", 32'(sat16), 32'(j >= 3));
         chk("sat_wrap16", 32'(wrap16), 32'd0);
`endif
      end
      step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
`ifdef MODN_COUNTER_SAT_EN
      chk("sat_dn16", 32'(count16), 32'd0);
      chk("sat_dn_flag16", 32'(sat16), 32'd1);
`endif
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
